// File: rtl/fifo_pkg.sv
// Shared pointer arithmetic for the async FIFO read/write controllers.
// Functions work on zero-extended vectors, so callers truncate to their own pointer width.
package fifo_pkg;

    localparam int FIFO_ADDR_W = 3;
    localparam int FIFO_PTR_W  = FIFO_ADDR_W + 1;
    localparam int FIFO_DEPTH  = 2 ** FIFO_ADDR_W;
    localparam int FIFO_MAX_W  = 32;

    function automatic logic [FIFO_MAX_W-1:0] bin2gray(input logic [FIFO_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FIFO_MAX_W-1:0] gray2bin(input logic [FIFO_MAX_W-1:0] g);
        logic [FIFO_MAX_W-1:0] b;
        b[FIFO_MAX_W-1] = g[FIFO_MAX_W-1];
        for (int i = FIFO_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
// Purely combinational, zero latency, no flow control.
module fifo_gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: registered empty/level/almost-empty, 1-cycle flag latency; reads while empty are refused and flagged.
// Optional saturating underflow counter on output underflow_cnt when FIFO_RD_UNDERFLOW_CNT_EN is defined.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W    = FIFO_ADDR_W,
    parameter int AEMPTY_TH = 2
) (
    input  logic              r_clk,
    input  logic              r_rstn,
    input  logic              r_inc,
    input  logic [ADDR_W:0]   sync_wr_ptr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   gray_rd_ptr,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_level,
    output logic              underflow
`ifdef FIFO_RD_UNDERFLOW_CNT_EN
    ,
    output logic [7:0]        underflow_cnt
`endif
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] AE_TH = PTR_W'(AEMPTY_TH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] gray_q, gray_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             empty_q, empty_d;
    logic             aempty_q, aempty_d;
    logic             uflow_q, uflow_d;
    logic [PTR_W-1:0] wr_bin;

    fifo_gray2bin #(.WIDTH(PTR_W)) u_wr_g2b (
        .gray_i (sync_wr_ptr),
        .bin_o  (wr_bin)
    );

    // The registered empty flag gates reads, so the pointer can never pass the write pointer.
    assign rd_en = r_inc & ~empty_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
        gray_d   = rd_ptr_d ^ (rd_ptr_d >> 1);
        level_d  = wr_bin - rd_ptr_d;
        empty_d  = (gray_d == sync_wr_ptr);
        aempty_d = (level_d <= AE_TH);
        uflow_d  = r_inc & empty_q;
    end

    always_ff @(posedge r_clk) begin
        if (!r_rstn) begin
            rd_ptr_q <= '0;
            gray_q   <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            uflow_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            gray_q   <= gray_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            uflow_q  <= uflow_d;
        end
    end

    assign rd_addr      = rd_ptr_q[ADDR_W-1:0];
    assign gray_rd_ptr  = gray_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign rd_level     = level_q;
    assign underflow    = uflow_q;

`ifdef FIFO_RD_UNDERFLOW_CNT_EN
    logic [7:0] uf_cnt_q, uf_cnt_d;

    // Counts registered underflow pulses; sticks at all-ones, cleared only by reset.
    always_comb begin
        uf_cnt_d = uf_cnt_q;
        if (uflow_q && (uf_cnt_q != 8'hFF)) begin
            uf_cnt_d = uf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge r_clk) begin
        if (!r_rstn) begin
            uf_cnt_q <= '0;
        end else begin
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign underflow_cnt = uf_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl (ADDR_W=3, AEMPTY_TH=2): directed plan steps plus randomized traffic.
module tb_fifo_rd_ctrl;

    logic       r_clk = 1'b0;
    logic       r_rstn;
    logic       r_inc;
    logic [3:0] sync_wr_ptr;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic [3:0] gray_rd_ptr;
    logic       empty;
    logic       almost_empty;
    logic [3:0] rd_level;
    logic       underflow;
`ifdef FIFO_RD_UNDERFLOW_CNT_EN
    logic [7:0] underflow_cnt;
`endif

    fifo_rd_ctrl #(.ADDR_W(3), .AEMPTY_TH(2)) dut (
        .r_clk        (r_clk),
        .r_rstn       (r_rstn),
        .r_inc        (r_inc),
        .sync_wr_ptr  (sync_wr_ptr),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .gray_rd_ptr  (gray_rd_ptr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level),
        .underflow    (underflow)
`ifdef FIFO_RD_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt(underflow_cnt)
`endif
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        logic       rd_en;
        logic [2:0] addr;
        logic [3:0] gray;
        logic       empty;
        logic       ae;
        logic [3:0] level;
        logic       uf;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   stim_done = 1'b0;

    // Reference model: read/write counts as unbounded integers; flags hold the value after the last edge.
    int   rd_total = 0;
    int   wr_total = 0;
    bit   m_empty  = 1'b1;
    bit   m_ae     = 1'b1;
    int   m_level  = 0;
    bit   m_uf     = 1'b0;
    int   m_cnt    = 0;

    function automatic logic [3:0] to_gray(input int n);
        logic [3:0] b;
        b = 4'(n % 16);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus, entered and left at posedge+1.
    task automatic cycle(input bit inc, input bit wadv, input bit rstn);
        exp_t e;
        bit   acc;
        if (!rstn) wr_total = 0;
        else if (wadv) wr_total++;
        r_rstn      = rstn;
        r_inc       = inc;
        sync_wr_ptr = to_gray(wr_total);

        e.rd_en = inc && !m_empty;
        e.addr  = 3'(rd_total % 8);
        e.gray  = to_gray(rd_total);
        e.empty = m_empty;
        e.ae    = m_ae;
        e.level = 4'(m_level);
        e.uf    = m_uf;
        e.cnt   = 8'(m_cnt);
        sb.push_back(e);

        if (!rstn) begin
            rd_total = 0;
            m_empty  = 1'b1;
            m_ae     = 1'b1;
            m_level  = 0;
            m_uf     = 1'b0;
            m_cnt    = 0;
        end else begin
            acc = inc && !m_empty;
            if (m_uf && m_cnt < 255) m_cnt++;
            m_uf     = inc && m_empty;
            rd_total = rd_total + int'(acc);
            m_level  = wr_total - rd_total;
            m_empty  = (m_level == 0);
            m_ae     = (m_level <= 2);
        end
        @(posedge r_clk);
        #1;
    endtask

    // Monitor: compares everything the DUT shows mid-cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge r_clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rd_en",        32'(rd_en),        32'(e.rd_en));
                chk("rd_addr",      32'(rd_addr),      32'(e.addr));
                chk("gray_rd_ptr",  32'(gray_rd_ptr),  32'(e.gray));
                chk("empty",        32'(empty),        32'(e.empty));
                chk("almost_empty", 32'(almost_empty), 32'(e.ae));
                chk("rd_level",     32'(rd_level),     32'(e.level));
                chk("underflow",    32'(underflow),    32'(e.uf));
`ifdef FIFO_RD_UNDERFLOW_CNT_EN
                chk("underflow_cnt", 32'(underflow_cnt), 32'(e.cnt));
`endif
            end
        end
    end

    initial begin
        int p_rd;
        int p_wr;
        bit inc;
        bit wadv;

        r_rstn      = 1'b0;
        r_inc       = 1'b1;
        sync_wr_ptr = 4'b0000;
        @(posedge r_clk);
        #1;

        // Reset held with a read request, then fill to 5 and drain.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1);

        // Three reads against an empty FIFO, then idle so the counter settles.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1);

        // Fill to full (level 8, same address different lap), then drain to empty.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b1);

        // Streaming through the pointer wrap.
        for (int i = 0; i < 22; i++) cycle(i > 0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);

        // Level 3 held with simultaneous write advance and read, then reset mid-stream.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);

        // Randomized traffic in phases of differing read/write bias.
        for (int ph = 0; ph < 8; ph++) begin
            p_rd = $urandom_range(10, 90);
            p_wr = $urandom_range(10, 90);
            for (int i = 0; i < 80; i++) begin
                inc  = ($urandom_range(0, 99) < p_rd);
                wadv = (wr_total - rd_total < 8) && ($urandom_range(0, 99) < p_wr);
                cycle(inc, wadv, ($urandom_range(0, 199) != 0));
            end
        end
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);

        stim_done = 1'b1;
        repeat (3) @(negedge r_clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        if (!stim_done) begin
            $display("FAIL timeout: bench did not complete within time limit");
            $fatal(1);
        end
    end

endmodule
